// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control sequencer.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (see multicycle_main_fsm.sv).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    // Instruction class (Instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Data-processing cmd field (Instr[24:21])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes (Instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Datapath mux encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // True for the data-processing commands this core implements
    function automatic logic cmd_legal(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
               (cmd == CMD_ORR) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// enables and mux selects out. There is no handshake: every signal is
// meaningful every cycle. dbg_* expose sequencer state for observation only.
interface multicycle_main_fsm_if;
    import mc_ctrl_pkg::*;

    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic       Halted;

    state_t     dbg_state;
    logic [3:0] dbg_flags;
    logic       dbg_condex;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Halted,
               dbg_state, dbg_flags, dbg_condex
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Halted,
               dbg_state, dbg_flags, dbg_condex
    );
endinterface

// File: rtl/mc_cond_unit.sv
// NZCV flags register, flag-write masking, condition evaluation and the
// registered condition-pass bit (condex_q) used by the write-back states.
module mc_cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cond_en,     // high in DECODE: capture condition result
    input  logic [3:0] i_cond,
    input  logic [1:0] i_flag_w,      // [1] writes N,Z; [0] writes C,V
    input  logic [3:0] i_alu_flags,
    output logic       o_condex,
    output logic [3:0] o_flags
);
    logic [3:0] r_flags;
    logic       r_condex;
    logic       w_cond_true;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluate Cond against the current flags register
    always_comb begin
        w_cond_true = 1'b0;
        case (i_cond)
            COND_EQ: w_cond_true = w_z;
            COND_NE: w_cond_true = ~w_z;
            COND_CS: w_cond_true = w_c;
            COND_CC: w_cond_true = ~w_c;
            COND_MI: w_cond_true = w_n;
            COND_PL: w_cond_true = ~w_n;
            COND_VS: w_cond_true = w_v;
            COND_VC: w_cond_true = ~w_v;
            COND_HI: w_cond_true = w_c & ~w_z;
            COND_LS: w_cond_true = ~w_c | w_z;
            COND_GE: w_cond_true = (w_n == w_v);
            COND_LT: w_cond_true = (w_n != w_v);
            COND_GT: w_cond_true = ~w_z & (w_n == w_v);
            COND_LE: w_cond_true = w_z | (w_n != w_v);
            COND_AL: w_cond_true = 1'b1;
            COND_NV: w_cond_true = 1'b0;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Flags update only when the executing instruction passed its condition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags  <= 4'b0000;
            r_condex <= 1'b0;
        end else begin
            if (i_cond_en) begin
                r_condex <= w_cond_true;
            end
            if (i_flag_w[1] && r_condex) begin
                r_flags[3:2] <= i_alu_flags[3:2];
            end
            if (i_flag_w[0] && r_condex) begin
                r_flags[1:0] <= i_alu_flags[1:0];
            end
        end
    end

    assign o_condex = r_condex;
    assign o_flags  = r_flags;

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control sequencer of the multicycle ARM-subset core: state machine,
// per-state datapath controls and ALU decode.
// Optional feature macro: ILLEGAL_OP_TRAP_EN -- when defined, Op=11 or an
// unimplemented data-processing cmd parks the sequencer in HALT until reset.
module multicycle_main_fsm
    import mc_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    multicycle_main_fsm_if.master   bus
);
`ifdef ILLEGAL_OP_TRAP_EN
    localparam state_t L_ILLEGAL_NEXT = S_HALT;
`else
    localparam state_t L_ILLEGAL_NEXT = S_FETCH;
`endif

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_st;
    logic [3:0] w_cmd;
    logic       w_imm;
    logic       w_s;
    logic       w_condex;
    logic [3:0] w_flags;
    logic [1:0] w_flag_w;
    logic [1:0] w_alu_ctl;

    assign w_cmd = bus.Funct[4:1];
    assign w_imm = bus.Funct[5];
    assign w_s   = bus.Funct[0];

    mc_cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .i_cond_en   (r_state == S_DECODE),
        .i_cond      (bus.Cond),
        .i_flag_w    (w_flag_w),
        .i_alu_flags (bus.ALUFlags),
        .o_condex    (w_condex),
        .o_flags     (w_flags)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_MEM: w_next_state = S_MEMADR;
                    OP_BR:  w_next_state = S_BRANCH;
                    OP_DP: begin
                        if (!cmd_legal(w_cmd)) w_next_state = L_ILLEGAL_NEXT;
                        else if (w_imm)        w_next_state = S_EXECUTEI;
                        else                   w_next_state = S_EXECUTER;
                    end
                    OP_UND: w_next_state = L_ILLEGAL_NEXT;
                    default: w_next_state = L_ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR:   w_next_state = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI: w_next_state = (w_cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BRANCH:   w_next_state = S_FETCH;
            S_HALT:     w_next_state = S_HALT;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // ALU operation and flag-write mask from cmd/S
    always_comb begin
        w_alu_ctl = ALU_ADD;
        w_flag_w  = 2'b00;
        case (w_cmd)
            CMD_ADD: w_alu_ctl = ALU_ADD;
            CMD_SUB,
            CMD_CMP: w_alu_ctl = ALU_SUB;
            CMD_AND: w_alu_ctl = ALU_AND;
            CMD_ORR: w_alu_ctl = ALU_ORR;
            default: w_alu_ctl = ALU_ADD;
        endcase
        if (r_state == S_EXECUTER || r_state == S_EXECUTEI) begin
            if (w_cmd == CMD_CMP)                             w_flag_w = 2'b11;
            else if (w_s && (w_cmd == CMD_ADD || w_cmd == CMD_SUB)) w_flag_w = 2'b11;
            else if (w_s && (w_cmd == CMD_AND || w_cmd == CMD_ORR)) w_flag_w = 2'b10;
        end
    end

    // Moore output decode; reset shows FETCH selects with all writes masked
    always_comb begin
        w_st           = reset ? S_FETCH : r_state;
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = SRCB_REG;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUControl = ALU_ADD;
        bus.Halted     = 1'b0;
        case (w_st)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
            end
            S_MEMADR:   bus.ALUSrcB = SRCB_IMM;
            S_MEMREAD:  bus.AdrSrc  = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = w_condex;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = w_condex;
            end
            S_EXECUTER: begin
                bus.ALUSrcB    = SRCB_REG;
                bus.ALUControl = w_alu_ctl;
            end
            S_EXECUTEI: begin
                bus.ALUSrcB    = SRCB_IMM;
                bus.ALUControl = w_alu_ctl;
            end
            S_ALUWB: begin
                bus.RegWrite = w_condex;
                bus.PCWrite  = w_condex & (bus.Rd == 4'd15);
            end
            S_BRANCH: begin
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALURES;
                bus.PCWrite   = w_condex;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_HALT:     bus.Halted = 1'b1;
`endif
            default: ;
        endcase
        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
        end
    end

    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
    assign bus.dbg_state  = r_state;
    assign bus.dbg_flags  = w_flags;
    assign bus.dbg_condex = w_condex;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: directed instruction scenarios followed by
// random instructions, each checked cycle by cycle against a per-instruction
// model of the expected control outputs and the architectural NZCV flags.
module tb_multicycle_main_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  multicycle_main_fsm_if bus();

  multicycle_main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]  m_flags;        // model NZCV
  logic [16:0] exp_q[$];       // expected output vectors, one per cycle

  // ---------------- scoreboard helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [16:0] dut_vec();
    return {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl,
            bus.ImmSrc, bus.RegSrc, bus.Halted};
  endfunction

  function automatic logic [16:0] mk(input logic [1:0] op,
                                     input logic pcw, input logic irw, input logic rw,
                                     input logic mw, input logic adr, input logic srca,
                                     input logic [1:0] srcb, input logic [1:0] res,
                                     input logic [1:0] aluc, input logic halt);
    return {pcw, irw, rw, mw, adr, srca, srcb, res, aluc, op,
            (op == 2'b01), (op == 2'b10), halt};
  endfunction

  // ARM condition: even codes test a predicate, odd codes its inverse
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    if (cond == 4'hE) return 1'b1;
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return cond[0] ? !base : base;
  endfunction

  function automatic logic is_legal_cmd(input logic [3:0] cmd);
    return cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
  endfunction

  // ---------------- driver / model ----------------
  // Runs one instruction from FETCH. reset_at >= 0 asserts reset in that cycle.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] aluf, input int reset_at);
    logic       c;
    logic [3:0] cmd;
    logic [1:0] aluc;
    logic       legal;
    int         k;
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.ALUFlags = aluf;
    cmd   = funct[4:1];
    c     = cond_true(cond, m_flags);
    legal = (op == 2'b01) || (op == 2'b10) || (op == 2'b00 && is_legal_cmd(cmd));
    case (cmd)
      4'b0010, 4'b1010: aluc = 2'd1;
      4'b0000:          aluc = 2'd2;
      4'b1100:          aluc = 2'd3;
      default:          aluc = 2'd0;
    endcase
    exp_q.delete();
    exp_q.push_back(mk(op, 1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 0));  // fetch
    exp_q.push_back(mk(op, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 0));  // decode
    if (!legal) begin
`ifdef ILLEGAL_OP_TRAP_EN
      for (int h = 0; h < 3; h++) exp_q.push_back(mk(op, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1));
`endif
    end else if (op == 2'b01) begin
      exp_q.push_back(mk(op, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0));
      if (funct[0]) begin
        exp_q.push_back(mk(op, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0));
        exp_q.push_back(mk(op, 0, 0, c, 0, 0, 0, 2'd0, 2'd1, 2'd0, 0));
      end else begin
        exp_q.push_back(mk(op, 0, 0, 0, c, 1, 0, 2'd0, 2'd0, 2'd0, 0));
      end
    end else if (op == 2'b10) begin
      exp_q.push_back(mk(op, c, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 0));
    end else begin
      exp_q.push_back(mk(op, 0, 0, 0, 0, 0, 0, funct[5] ? 2'd1 : 2'd0, 2'd0, aluc, 0));
      if (cmd != 4'b1010)
        exp_q.push_back(mk(op, c && (rd == 4'd15), 0, c, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0));
    end

    k = 0;
    while (exp_q.size() > 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_eq("reset_mid", 32'(dut_vec()), 32'(mk(op, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 0)));
        @(posedge clk); #1;
        reset   = 1'b0;
        m_flags = 4'b0000;
        check_eq("flags_after_reset", 32'(bus.dbg_flags), 32'(m_flags));
        exp_q.delete();
        return;
      end
      @(negedge clk);
      check_eq($sformatf("cyc%0d_op%0d_cmd%0h", k, op, cmd), 32'(dut_vec()), 32'(e));
      @(posedge clk); #1;
      k++;
    end

    if (!legal) begin
`ifdef ILLEGAL_OP_TRAP_EN
      // Trap only clears on reset
      reset = 1'b1;
      @(negedge clk);
      check_eq("reset_halt", 32'(dut_vec()), 32'(mk(op, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 0)));
      @(posedge clk); #1;
      reset   = 1'b0;
      m_flags = 4'b0000;
`endif
    end else if (op == 2'b00 && c) begin
      if (cmd == 4'b1010 || (funct[0] && (cmd == 4'b0100 || cmd == 4'b0010)))
        m_flags = aluf;
      else if (funct[0])
        m_flags = {aluf[3:2], m_flags[1:0]};
    end
    check_eq("flags", 32'(bus.dbg_flags), 32'(m_flags));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] cmds[5];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    reset = 1'b1;
    bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'b001000; bus.Rd = 4'd0; bus.ALUFlags = 4'h0;
    m_flags = 4'b0000;
    @(negedge clk);
    check_eq("reset_outputs", 32'(dut_vec()), 32'(mk(2'b00, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 0)));
    @(posedge clk); #1;
    check_eq("reset_flags", 32'(bus.dbg_flags), 32'(4'b0000));
    reset = 1'b0;

    // Directed scenarios
    run_instr(4'hE, 2'b00, 6'b001000, 4'd1,  4'hF, -1);  // ADD, S=0: flags unchanged
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1,  4'b0100, -1);  // SUBS -> Z
    run_instr(4'h0, 2'b10, 6'b100000, 4'd0,  4'h0, -1);  // BEQ taken
    run_instr(4'h1, 2'b10, 6'b100000, 4'd0,  4'h0, -1);  // BNE not taken
    run_instr(4'hE, 2'b01, 6'b011001, 4'd2,  4'h0, -1);  // LDR
    run_instr(4'hE, 2'b01, 6'b011000, 4'd2,  4'h0, -1);  // STR
    run_instr(4'hE, 2'b00, 6'b001001, 4'd3,  4'b0011, -1);  // ADDS -> 0011
    run_instr(4'hE, 2'b00, 6'b011001, 4'd3,  4'b1011, -1);  // ORRS keeps C,V
    run_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, -1);  // ADD to PC
    run_instr(4'hE, 2'b00, 6'b110101, 4'd0,  4'b1000, -1);  // CMP imm, 3 cycles
    run_instr(4'hF, 2'b00, 6'b001001, 4'd4,  4'b0110, -1);  // NV: no writes
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0,  4'h0, -1);  // undefined op
    run_instr(4'hE, 2'b00, 6'b011110, 4'd0,  4'h0, -1);  // unlisted cmd
    run_instr(4'hE, 2'b01, 6'b011000, 4'd2,  4'h0, 3);   // reset during MEMWRITE

    // Random instructions
    for (int i = 0; i < 250; i++) begin
      int         sel;
      logic [1:0] op;
      logic [3:0] cmd, cond;
      int         rst_at;
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      cmd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : cmds[$urandom_range(0, 4)];
      cond = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1) : -1;
      run_instr(cond, op, {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))},
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rst_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
